// File: rtl/decode_issue_buffer.sv
// Two-entry decode->execute skid buffer with load-use bubble insertion and flush.
// Optional stall-cycle counter enabled by defining STALL_COUNT_EN.
module decode_issue_buffer #(
    parameter int CTL_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hazard_bubble,
    input  logic             flush,
    input  logic [63:0]      in_pc,
    input  logic [63:0]      in_rd1,
    input  logic [63:0]      in_rd2,
    input  logic [4:0]       in_dst,
    input  logic             in_ismem,
    input  logic             in_write,
    input  logic [CTL_W-1:0] in_ctl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pc,
    output logic [63:0]      out_rd1,
    output logic [63:0]      out_rd2,
    output logic [4:0]       out_dst,
    output logic             out_ismem,
    output logic             out_write,
    output logic [CTL_W-1:0] out_ctl,
    output logic             out_bubble,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [63:0]      pc;
        logic [63:0]      rd1;
        logic [63:0]      rd2;
        logic [4:0]       dst;
        logic             ismem;
        logic             write;
        logic [CTL_W-1:0] ctl;
    } entry_t;

    state_t state_reg, state_next;
    entry_t head_reg, head_next;
    entry_t skid_reg, skid_next;
    entry_t in_entry;
    logic   in_ready_reg;
    logic   accept;
    logic   pop;

    assign in_entry = '{pc: in_pc, rd1: in_rd1, rd2: in_rd2, dst: in_dst,
                        ismem: in_ismem, write: in_write, ctl: in_ctl};

    assign out_valid  = (state_reg != EMPTY);
    assign out_bubble = ~out_valid;
    assign in_ready   = in_ready_reg;

    assign out_pc    = head_reg.pc;
    assign out_rd1   = head_reg.rd1;
    assign out_rd2   = head_reg.rd2;
    assign out_dst   = head_reg.dst;
    assign out_ismem = head_reg.ismem;
    assign out_write = head_reg.write;
    assign out_ctl   = head_reg.ctl;

    assign accept = in_valid & in_ready_reg & ~hazard_bubble & ~flush;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        skid_next  = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    head_next  = in_entry;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_next = in_entry;
                end else if (accept) begin
                    skid_next  = in_entry;
                    state_next = TWO;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_next  = skid_reg;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush only kills valid bits; payload movement above is harmless.
        if (flush) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= EMPTY;
            head_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            head_reg     <= head_next;
            skid_reg     <= skid_next;
            in_ready_reg <= (state_next != TWO);
        end
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (in_valid && (hazard_bubble || !in_ready_reg) && !flush
                     && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/decode_issue_buffer.md
# decode_issue_buffer

Two-entry skid buffer between decode and execute. It captures the decoded instruction together with its forwarded operands once decode's operand selection has resolved them, and presents the instruction to execute with a valid/ready handshake. Its head entry drives the execute-stage destination, memory-op and bubble signals that decode's forwarding selection compares against. On a load-use hazard reported by decode operand selection, it inserts a bubble. It drops everything on a pipeline flush.

## Interface
- CTL_W, default 32: width of the opaque decoded control bundle passed through unchanged.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- in_valid  in  1  decode holds an instruction.
- in_ready  out  1  buffer can take an instruction; driven from a register (no combinational path from out_ready).
- hazard_bubble  in  1  load-use stall from decode operand selection, OR of both source operands.
- flush  in  1  branch/exception redirect.
- in_pc  in  64  instruction PC.
- in_rd1, in_rd2  in  64 each  forwarded source operands (word_t).
- in_dst  in  5  destination register (creg_addr_t).
- in_ismem, in_write  in  1 each  load/store flag and register-writeback flag.
- in_ctl  in  CTL_W  decoded control.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes the head.
- out_pc, out_rd1, out_rd2, out_dst, out_ismem, out_write, out_ctl  out  widths as above  head payload.
- out_bubble  out  1  equals ~out_valid; feeds the forwarding bubbleE input.
- stall_cnt  out  32  stall-cycle counter (see Configuration).

## Operation
- Storage: head entry (H) and skid entry (S), each a valid bit plus payload. State is encoded as EMPTY (neither valid), ONE (H only) or TWO (H and S).
- accept = in_valid & in_ready & ~hazard_bubble & ~flush.
- pop = out_valid & out_ready.
- in_ready is the registered value ~S.valid.
- Transitions:
  - EMPTY: accept → ONE, H loads the input.
  - ONE: accept & pop → ONE, H is replaced by the input. accept & ~pop → TWO, S loads the input. ~accept & pop → EMPTY. Otherwise stay in ONE.
  - TWO: in_ready = 0, so no accept is possible. pop → ONE, H takes S's payload and S is cleared. Otherwise stay in TWO.
- hazard_bubble with in_valid: the instruction is not accepted and decode holds it. Nothing enters, and H drains normally, so a bubble reaches execute.
- flush: H.valid and S.valid clear at the next edge. Flush has priority over accept and pop. A pop in the same cycle still completes at execute, and the payload is then discarded.
- Forwarding correctness: an instruction is accepted only when S is empty. Its operands were therefore selected against H, which is the only older in-flight decode-issued entry.
- Payload registers are not cleared when an entry is invalidated; only the valid bits are.

## Timing
- Reset values:
  - out_valid = 0, out_bubble = 1, in_ready = 1, all payload outputs = 0, stall_cnt = 0.
  - Internal state is EMPTY.
- Latency: an instruction accepted at edge N is presented with out_valid = 1 after edge N (1 cycle).
- Throughput: 1 instruction per cycle while out_ready stays high.
- in_ready falls the cycle after S fills. It rises the cycle after S drains or a flush occurs.
- Payload outputs are stable while out_valid & ~out_ready.
- Reset asserted mid-operation: all valid bits clear asynchronously. Outputs take their reset values without waiting for a clock edge.

## Configuration
- STALL_COUNT_EN defined:
  - stall_cnt increments on every cycle with in_valid & (hazard_bubble | ~in_ready) & ~flush.
  - It saturates at 0xFFFF_FFFF and is cleared by reset.
- STALL_COUNT_EN undefined: stall_cnt is tied to 0 and no counter is synthesized. The port remains present.

## Test plan
- Streaming: after reset, in_valid = 1 with out_ready = 1 for 4 cycles, PCs 0x80000000, +4, +8, +12 → the same PCs appear on out_pc one cycle later, with in_ready held at 1.
- Backpressure: out_ready = 0, push A then B → state is TWO and in_ready = 0 after the second edge. Raise out_ready → A is output, then B, and in_ready returns to 1 after B moves into H.
- Load-use: H holds a load to x5 (out_ismem = 1); decode drives in_dst = 6 with hazard_bubble = 1 for one cycle → out_valid = 0 in the following cycle, and the instruction is accepted in the next cycle.
- Flush: state TWO, flush = 1 together with out_ready = 1 → the next cycle has out_valid = 0, out_bubble = 1 and in_ready = 1, and no later output carries S's PC.
- Counter: with STALL_COUNT_EN defined, 3 hazard cycles plus 2 full-buffer cycles → stall_cnt = 5. With it undefined, stall_cnt = 0.
- Asynchronous reset: reset low mid-cycle while in TWO → out_valid drops to 0 before the next clock edge, and in_ready = 1.
